// File: rtl/loader_pkg.sv
// loader_pkg: shared states, byte counts and address strides for prog_loader.
// LOADER_VERIFY_EN adds the VFY_I/VFY_D read-back states.
package loader_pkg;
  localparam int HDR_BYTES = 4;
  localparam int IWORD_BYTES = 4;
  localparam int DWORD_BYTES = 8;
  localparam int IADDR_STRIDE = 4;
  localparam int DADDR_STRIDE = 8;
  typedef enum logic [3:0] {
    IDLE, HDR_N, HDR_M, LOAD_I, WR_I, LOAD_D, WR_D, RUN, ERROR
`ifdef LOADER_VERIFY_EN
    , VFY_I, VFY_D
`endif
  } state_t;
endpackage

// File: rtl/prog_loader_packer.sv
// byte_packer: little-endian byte-to-word packer; done_o pulses on the byte that completes a word.
module byte_packer (
  input  logic        clk,
  input  logic        arst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [2:0]  last_i,
  input  logic [7:0]  din_i,
  output logic [63:0] word_o,
  output logic        done_o
);
  logic [2:0]  cnt_q;
  logic [63:0] word_q;
  assign done_o = en_i && cnt_q == last_i;
  // word_o already contains the byte being accepted so headers can be checked on done_o
  always_comb begin
    word_o = word_q;
    if (en_i) word_o[{cnt_q, 3'b000} +: 8] = din_i;
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      word_q <= word_o;
      cnt_q  <= done_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams an N/M-prefixed image into cpu imem/dmem, then enables the cpu.
// Define LOADER_VERIFY_EN to read back every written word before RUN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] imem_addr,
  output logic        imem_wen,
  output logic        imem_ren,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wen,
  output logic        dmem_ren,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);
  localparam int IW = $clog2(IMEM_WORDS) + 1;
  localparam int DW = $clog2(DMEM_WORDS) + 1;
  state_t        state_q;
  logic [IW-1:0] n_q, i_q;
  logic [DW-1:0] m_q, j_q;
  logic [63:0]   word;
  logic          done, xfer, restart;
  assign s_ready    = state_q inside {HDR_N, HDR_M, LOAD_I, LOAD_D};
  assign xfer       = s_valid && s_ready;
  assign restart    = start && state_q inside {IDLE, RUN, ERROR};
  assign imem_wen   = state_q == WR_I;
  assign dmem_wen   = state_q == WR_D;
  assign imem_wdata = imem_wen ? word[31:0] : '0;
  assign dmem_wdata = dmem_wen ? word : '0;
  assign cpu_enable = state_q == RUN;
  assign error      = state_q == ERROR;
  byte_packer u_pack (
    .clk    (clk),
    .arst   (arst),
    .clr_i  (restart),
    .en_i   (xfer),
    .last_i (state_q == LOAD_D ? 3'(DWORD_BYTES - 1) :
             state_q == LOAD_I ? 3'(IWORD_BYTES - 1) : 3'(HDR_BYTES - 1)),
    .din_i  (s_data),
    .word_o (word),
    .done_o (done)
  );
`ifdef LOADER_VERIFY_EN
  localparam int KW = IW > DW ? IW : DW;
  localparam state_t AFTER_WR = VFY_I;
  logic [KW-1:0] k_q, idx_q;
  logic          pend_q, vfy_bad;
  logic [31:0]   ishadow [IMEM_WORDS];
  logic [63:0]   dshadow [DMEM_WORDS];
  assign busy      = s_ready || state_q inside {WR_I, WR_D, VFY_I, VFY_D};
  assign imem_ren  = state_q == VFY_I && k_q < KW'(n_q);
  assign dmem_ren  = state_q == VFY_D && k_q < KW'(m_q);
  assign imem_addr = imem_wen ? 64'(i_q) * 64'(IADDR_STRIDE) :
                     imem_ren ? 64'(k_q) * 64'(IADDR_STRIDE) : '0;
  assign dmem_addr = dmem_wen ? 64'(j_q) * 64'(DADDR_STRIDE) :
                     dmem_ren ? 64'(k_q) * 64'(DADDR_STRIDE) : '0;
  // read data for the address issued last cycle is checked against the shadow copy
  assign vfy_bad = pend_q && (state_q == VFY_I ? imem_rdata != ishadow[idx_q[IW-2:0]] :
                              state_q == VFY_D && dmem_rdata != dshadow[idx_q[DW-2:0]]);
  always_ff @(posedge clk) begin
    if (imem_wen) ishadow[i_q[IW-2:0]] <= word[31:0];
    if (dmem_wen) dshadow[j_q[DW-2:0]] <= word;
  end
`else
  localparam state_t AFTER_WR = RUN;
  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata, dmem_rdata};
  assign busy      = s_ready || state_q inside {WR_I, WR_D};
  assign imem_ren  = 1'b0;
  assign dmem_ren  = 1'b0;
  assign imem_addr = imem_wen ? 64'(i_q) * 64'(IADDR_STRIDE) : '0;
  assign dmem_addr = dmem_wen ? 64'(j_q) * 64'(DADDR_STRIDE) : '0;
`endif
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      m_q     <= '0;
      j_q     <= '0;
`ifdef LOADER_VERIFY_EN
      k_q     <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, RUN, ERROR: if (start) begin
          state_q <= HDR_N;
          n_q     <= '0;
          i_q     <= '0;
          m_q     <= '0;
          j_q     <= '0;
`ifdef LOADER_VERIFY_EN
          k_q     <= '0;
          pend_q  <= 1'b0;
`endif
        end
        HDR_N: if (done) begin
          n_q     <= word[IW-1:0];
          state_q <= word[31:0] > 32'(IMEM_WORDS) ? ERROR : HDR_M;
        end
        HDR_M: if (done) begin
          m_q     <= word[DW-1:0];
          state_q <= word[31:0] > 32'(DMEM_WORDS) ? ERROR :
                     n_q != '0 ? LOAD_I : word[31:0] != '0 ? LOAD_D : RUN;
        end
        LOAD_I: if (done) state_q <= WR_I;
        WR_I: begin
          i_q     <= i_q + 1'b1;
          state_q <= i_q + 1'b1 != n_q ? LOAD_I : m_q != '0 ? LOAD_D : AFTER_WR;
        end
        LOAD_D: if (done) state_q <= WR_D;
        WR_D: begin
          j_q     <= j_q + 1'b1;
          state_q <= j_q + 1'b1 != m_q ? LOAD_D : AFTER_WR;
        end
`ifdef LOADER_VERIFY_EN
        VFY_I, VFY_D: begin
          if (vfy_bad) begin
            state_q <= ERROR;
          end else if (imem_ren || dmem_ren) begin
            k_q    <= k_q + 1'b1;
            idx_q  <= k_q;
            pend_q <= 1'b1;
          end else begin
            k_q     <= '0;
            pend_q  <= 1'b0;
            state_q <= state_q == VFY_I ? VFY_D : RUN;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven image loads checked by a write scoreboard, plus reset-abort and verify corner cases.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        arst, start, s_valid, s_ready;
  logic [7:0]  s_data;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] imem_wdata, imem_rdata;
  logic        imem_wen, imem_ren, dmem_wen, dmem_ren, cpu_enable, busy, error;
  logic [31:0] imem_m [512];
  logic [63:0] dmem_m [1024];
  logic [31:0] iw [512];
  logic [63:0] dw [1024];
  bit          corrupt;
  int          total = 0, bad = 0;
  typedef struct {logic [63:0] a; logic [63:0] d;} wr_t;
  typedef struct {int n; int m; bit rnd; bit ms; bit fixed; bit exp_err; bit exp_en;} vec_t;
  wr_t  iq[$], dq[$];
  vec_t tv [10];
  prog_loader dut (
    .clk(clk), .arst(arst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );
  always #5 clk = ~clk;
  // one-cycle-latency memory model; corrupt flips bit 0 of imem word 1 on read
  always @(posedge clk) begin
    imem_rdata <= imem_m[imem_addr[10:2]] ^ ((corrupt && imem_addr == 64'd4) ? 32'h1 : 32'h0);
    dmem_rdata <= dmem_m[dmem_addr[12:3]];
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic mon();
    wr_t e;
    if (imem_wen) begin
      imem_m[imem_addr[10:2]] = imem_wdata;
      chk("imem_wen_with_enable", cpu_enable, 0);
      if (iq.size() == 0) chk("imem_spurious_write", imem_wen, 0);
      else begin
        e = iq.pop_front();
        chk("imem_addr", imem_addr, e.a);
        chk("imem_wdata", imem_wdata, e.d);
      end
    end
    if (dmem_wen) begin
      dmem_m[dmem_addr[12:3]] = dmem_wdata;
      chk("dmem_wen_with_enable", cpu_enable, 0);
      if (dq.size() == 0) chk("dmem_spurious_write", dmem_wen, 0);
      else begin
        e = dq.pop_front();
        chk("dmem_addr", dmem_addr, e.a);
        chk("dmem_wdata", dmem_wdata, e.d);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask
  task automatic send(input logic [7:0] b, input bit rnd, input bit st);
    int w = 0;
    if (rnd) repeat ($urandom_range(2, 0)) begin
      s_valid = 1'b0;
      step();
    end
    s_data  = b;
    s_valid = 1'b1;
    start   = st;
    while (!s_ready && w < 50) begin
      step();
      start = 1'b0;
      w++;
    end
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    step();
    start   = 1'b0;
    s_valid = 1'b0;
  endtask
  task automatic push_i(input int i, input logic [31:0] d);
    wr_t e;
    e.a = 64'(4 * i);
    e.d = 64'(d);
    iq.push_back(e);
  endtask
  task automatic push_d(input int j, input logic [63:0] d);
    wr_t e;
    e.a = 64'(8 * j);
    e.d = d;
    dq.push_back(e);
  endtask
  task automatic chk_idle_outs(input string nm);
    chk({nm, "_flags"}, {s_ready, busy, cpu_enable, error, imem_wen, dmem_wen, imem_ren, dmem_ren}, 0);
    chk({nm, "_imem_addr"}, imem_addr, 0);
    chk({nm, "_dmem_addr"}, dmem_addr, 0);
    chk({nm, "_imem_wdata"}, imem_wdata, 0);
    chk({nm, "_dmem_wdata"}, dmem_wdata, 0);
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] nn, mm, wi;
    logic [63:0] wd;
    int w;
    nn = v.n;
    mm = v.m;
    for (int i = 0; i < v.n && i < 512; i++) iw[i] = $urandom();
    for (int j = 0; j < v.m && j < 1024; j++) dw[j] = {$urandom(), $urandom()};
    if (v.fixed) begin
      iw[0] = 32'h00500093;
      iw[1] = 32'h00108133;
      dw[0] = 64'h1122334455667788;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_enable_low", cpu_enable, 0);
    for (int b = 0; b < 4; b++) send(nn[8*b +: 8], v.rnd, 1'b0);
    if (v.n > 512) begin
      chk("hdr_n_error", error, 1);
      chk("hdr_n_error_ready", s_ready, 0);
    end else begin
      for (int b = 0; b < 4; b++) send(mm[8*b +: 8], v.rnd, 1'b0);
      if (v.m <= 1024) begin
        for (int i = 0; i < v.n; i++) begin
          wi = iw[i];
          for (int b = 0; b < 4; b++) begin
            if (b == 3) push_i(i, wi);
            send(wi[8*b +: 8], v.rnd, v.ms && i == 0 && b == 2);
          end
        end
        for (int j = 0; j < v.m; j++) begin
          wd = dw[j];
          for (int b = 0; b < 8; b++) begin
            if (b == 7) push_d(j, wd);
            send(wd[8*b +: 8], v.rnd, 1'b0);
          end
        end
        if (v.n + v.m > 0) chk("last_write_strobe", imem_wen | dmem_wen, 1);
      end
    end
    w = 0;
    while (busy && w < 5000) begin
      step();
      w++;
    end
    chk("final_busy", busy, 0);
`ifndef LOADER_VERIFY_EN
    if (v.n + v.m > 0 && !v.exp_err) chk("enable_latency", w, 1);
`endif
    if (v.n + v.m == 0 || v.exp_err) chk("direct_latency", w, 0);
    chk("final_error", error, v.exp_err);
    chk("final_enable", cpu_enable, v.exp_en);
    chk("final_s_ready", s_ready, 0);
    chk("imem_missing_writes", iq.size(), 0);
    chk("dmem_missing_writes", dq.size(), 0);
    iq.delete();
    dq.delete();
  endtask
  initial begin
    tv[0] = '{2, 1, 0, 0, 1, 0, 1};
    tv[1] = '{0, 0, 0, 0, 0, 0, 1};
    tv[2] = '{513, 0, 0, 0, 0, 1, 0};
    tv[3] = '{2, 1, 1, 1, 1, 0, 1};
    tv[4] = '{0, 1025, 0, 0, 0, 1, 0};
    tv[5] = '{512, 1, 0, 0, 0, 0, 1};
    tv[6] = '{1, 0, 1, 0, 0, 0, 1};
    tv[7] = '{3, 2, 1, 0, 0, 0, 1};
    tv[8] = '{0, 1024, 0, 0, 0, 0, 1};
    tv[9] = '{1, 1, 0, 0, 0, 0, 1};
    arst    = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    corrupt = 1'b0;
    step();
    step();
    chk_idle_outs("reset");
    arst = 1'b0;
    step();
    chk_idle_outs("idle");
    for (int t = 0; t < 10; t++) run_vec(tv[t]);
    // abort mid LOAD_D: N=1, M=2, second doubleword cut after 3 bytes
    start = 1'b1;
    step();
    start = 1'b0;
    send(8'd1, 1'b0, 1'b0);
    repeat (3) send(8'd0, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0);
    repeat (3) send(8'd0, 1'b0, 1'b0);
    push_i(0, 32'hDEADBEEF);
    for (int b = 0; b < 4; b++) send(8'(32'hDEADBEEF >> (8 * b)), 1'b0, 1'b0);
    push_d(0, 64'h0102030405060708);
    for (int b = 0; b < 8; b++) send(8'(64'h0102030405060708 >> (8 * b)), 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) send(8'hA0 + 8'(b), 1'b0, 1'b0);
    chk("pre_abort_ready", s_ready, 1);
    arst = 1'b1;
    #1;
    chk_idle_outs("async_abort");
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) step();
    chk("abort_imem_pending", iq.size(), 0);
    chk("abort_dmem_pending", dq.size(), 0);
    s_valid = 1'b0;
    arst = 1'b0;
    step();
    chk_idle_outs("after_abort");
    run_vec(tv[0]);
`ifdef LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_vec('{2, 1, 0, 0, 1, 1, 0});
    corrupt = 1'b0;
    run_vec(tv[7]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
